mem_pair_issue: RTL
===================

MEM_PAIR_ISSUE -- requirements
Module: mem_pair_issue

Interface
REQ-001 Parameter CNT_W, default 16, width of split-event counter.
REQ-002 clock  input  1  clock, all state on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  synchronous discard of all held and pending ops.
REQ-005 in_valid  input  1  EX stage offers a memory pair.
REQ-006 in_ready  output  1  pair accepted on edge where in_valid && in_ready.
REQ-007 in_first  input  1  age order: 0 = slot 1 older, 1 = slot 2 older.
REQ-008 in_op_valid_1/_2  input  1 each  slot holds a memory op.
REQ-009 in_addr_1/_2  input  32 each  byte address.
REQ-010 in_size_1/_2  input  2 each  DM_WORD/DM_HALF/DM_BYTE encoding from shared defs.
REQ-011 in_signed_1/_2  input  1 each  sign-extend load result.
REQ-012 in_we_1/_2  input  1 each  op is a store.
REQ-013 in_wdata_1/_2  input  32 each  store data.
REQ-014 dm_addr/size/signed/we/wdata_1/_2  output  as inputs  registered data-memory request per slot.
REQ-015 dm_first  output  1  registered age order for data memory.
REQ-016 out_valid  output  1  dm_* carry at least one live op this cycle.
REQ-017 split_count  output  CNT_W  saturating count of split pairs.

Function
REQ-018 State machine SHALL have states IDLE, PAIR, SPLIT_OLD, SPLIT_YOUNG.
REQ-019 Word match SHALL compare addr[12:2] of both slots.
REQ-020 Conflict SHALL be: both op_valid, older we=1, words match, and younger is a load or a store with size != DM_WORD.
REQ-021 in_ready SHALL be 0 in SPLIT_OLD or when flush=1, else 1.
REQ-022 Accepted pair without conflict: next state PAIR; dm_* show both slots, out_valid=1, for exactly one cycle.
REQ-023 Accepted pair with conflict: next state SPLIT_OLD; dm_* show older slot only, younger slot idle.
REQ-024 SPLIT_OLD SHALL always advance to SPLIT_YOUNG next edge; dm_* show younger slot only, older slot idle.
REQ-025 Slots SHALL keep their position; dm_first = captured in_first in PAIR and both split states.
REQ-026 Idle slot (op_valid=0 or split-suppressed) SHALL drive addr=0, size=DM_WORD, signed=0, we=0, wdata=0.
REQ-027 In PAIR or SPLIT_YOUNG with no accept, next state IDLE, out_valid=0, both slots idle.
REQ-028 Accept in PAIR or SPLIT_YOUNG SHALL give back-to-back issue with no bubble.
REQ-029 Pair with both op_valid=0 SHALL be accepted and produce PAIR with out_valid=0.
REQ-030 Pair with single live op SHALL never conflict.
REQ-031 split_count SHALL increment by 1 on each conflicting accept, saturating at all-ones.
REQ-032 flush=1 SHALL force IDLE next edge, drop pending younger op, ignore in_valid; split_count unchanged.
REQ-033 Latency in_valid accept to dm_* SHALL be exactly 1 cycle; younger op of a split 2 cycles.

Reset
REQ-034 reset SHALL override flush and in_valid.
REQ-035 After reset: state IDLE, out_valid=0, both slots idle, dm_first=0, split_count=0, in_ready=1.
REQ-036 reset in SPLIT_OLD SHALL discard the pending younger op.

Verification
REQ-037 Slot1 store word 0x100 older, slot2 load word 0x200 -> next cycle both live, out_valid=1, split_count=0.
REQ-038 in_first=1, slot2 store byte 0x103, slot1 load half 0x100 -> cycle+1 slot2 only, cycle+2 slot1 only, in_ready=0 in cycle+1, split_count=1.
REQ-039 Older store word 0x40, younger store word 0x44 then younger store word 0x40 -> first pair no split, second pair no split; younger store half 0x42 -> split.
REQ-040 Conflict pair followed by in_valid held high with new pair -> new pair issues the cycle after SPLIT_YOUNG, no gap.
REQ-041 flush asserted in SPLIT_OLD -> next cycle out_valid=0, younger op never issued; reset in SPLIT_OLD -> same, split_count=0.
REQ-042 Force split_count to 0xFFFE, issue three conflicting pairs -> reads 0xFFFF and stays.

Source files
------------

// File: rtl/mem_pair_issue_if.sv
// Bundle between the EX stage and the data-memory port of the pair issuer.
// Carries the offered pair, the ready handshake and the per-slot requests
// going to data memory.
interface mem_pair_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_first;
    logic        in_op_valid_1;
    logic        in_op_valid_2;
    logic [31:0] in_addr_1;
    logic [31:0] in_addr_2;
    logic [1:0]  in_size_1;
    logic [1:0]  in_size_2;
    logic        in_signed_1;
    logic        in_signed_2;
    logic        in_we_1;
    logic        in_we_2;
    logic [31:0] in_wdata_1;
    logic [31:0] in_wdata_2;

    logic [31:0] dm_addr_1;
    logic [31:0] dm_addr_2;
    logic [1:0]  dm_size_1;
    logic [1:0]  dm_size_2;
    logic        dm_signed_1;
    logic        dm_signed_2;
    logic        dm_we_1;
    logic        dm_we_2;
    logic [31:0] dm_wdata_1;
    logic [31:0] dm_wdata_2;
    logic        dm_first;
    logic        out_valid;

    // EX stage / bench side
    modport master (
        output in_valid, in_first, in_op_valid_1, in_op_valid_2,
               in_addr_1, in_addr_2, in_size_1, in_size_2,
               in_signed_1, in_signed_2, in_we_1, in_we_2,
               in_wdata_1, in_wdata_2,
        input  in_ready,
               dm_addr_1, dm_addr_2, dm_size_1, dm_size_2,
               dm_signed_1, dm_signed_2, dm_we_1, dm_we_2,
               dm_wdata_1, dm_wdata_2, dm_first, out_valid
    );

    // Issuer side
    modport slave (
        input  in_valid, in_first, in_op_valid_1, in_op_valid_2,
               in_addr_1, in_addr_2, in_size_1, in_size_2,
               in_signed_1, in_signed_2, in_we_1, in_we_2,
               in_wdata_1, in_wdata_2,
        output in_ready,
               dm_addr_1, dm_addr_2, dm_size_1, dm_size_2,
               dm_signed_1, dm_signed_2, dm_we_1, dm_we_2,
               dm_wdata_1, dm_wdata_2, dm_first, out_valid
    );
endinterface

// File: rtl/mem_pair_issue.sv
// Dual-slot memory issue stage. A pair of memory ops from EX is normally sent
// to data memory together one cycle later. When the older op is a store and
// the younger op touches the same word in a way that cannot be merged (a load,
// or a partial store), the pair is split: older op first, younger op on the
// following cycle. Slots never swap position; only the unused slot is idled.
module mem_pair_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    mem_pair_issue_if.slave  bus,
    output logic [CNT_W-1:0] split_count
);

    localparam logic [1:0] DM_WORD = 2'b00;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PAIR        = 2'd1,
        SPLIT_OLD   = 2'd2,
        SPLIT_YOUNG = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic        we;
        logic [31:0] wdata;
    } slot_t;

    localparam slot_t SLOT_IDLE = '{addr: 32'h0, size: DM_WORD, sgn: 1'b0,
                                    we: 1'b0, wdata: 32'h0};

    // A slot without a live op must present a quiet, all-default request.
    function automatic slot_t f_live(input logic valid, input slot_t s);
        f_live = valid ? s : SLOT_IDLE;
    endfunction

    state_t           r_state;
    slot_t            r_d1;
    slot_t            r_d2;
    slot_t            r_pend;
    logic             r_pend_slot2;
    logic             r_first;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_split_count;

    slot_t w_s1;
    slot_t w_s2;
    slot_t w_old;
    slot_t w_yng;
    logic  w_word_match;
    logic  w_conflict;
    logic  w_in_ready;
    logic  w_accept;

    // Decode the offered pair into older/younger views and detect a conflict.
    always_comb begin
        w_s1 = '{addr: bus.in_addr_1, size: bus.in_size_1, sgn: bus.in_signed_1,
                 we: bus.in_we_1, wdata: bus.in_wdata_1};
        w_s2 = '{addr: bus.in_addr_2, size: bus.in_size_2, sgn: bus.in_signed_2,
                 we: bus.in_we_2, wdata: bus.in_wdata_2};
        if (bus.in_first) begin
            w_old = w_s2;
            w_yng = w_s1;
        end else begin
            w_old = w_s1;
            w_yng = w_s2;
        end
        w_word_match = (bus.in_addr_1[12:2] == bus.in_addr_2[12:2]);
        w_conflict   = bus.in_op_valid_1 && bus.in_op_valid_2 && w_old.we &&
                       w_word_match && (!w_yng.we || (w_yng.size != DM_WORD));
    end

    // The pending younger op of a split blocks new pairs for one cycle.
    assign w_in_ready = (r_state != SPLIT_OLD) && !flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Issue FSM: owns state, the registered data-memory request and the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_d1          <= SLOT_IDLE;
            r_d2          <= SLOT_IDLE;
            r_pend        <= SLOT_IDLE;
            r_pend_slot2  <= 1'b0;
            r_first       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_split_count <= '0;
        end else if (flush) begin
            r_state      <= IDLE;
            r_d1         <= SLOT_IDLE;
            r_d2         <= SLOT_IDLE;
            r_pend       <= SLOT_IDLE;
            r_pend_slot2 <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                SPLIT_OLD: begin
                    r_state     <= SPLIT_YOUNG;
                    r_d1        <= r_pend_slot2 ? SLOT_IDLE : r_pend;
                    r_d2        <= r_pend_slot2 ? r_pend : SLOT_IDLE;
                    r_pend      <= SLOT_IDLE;
                    r_out_valid <= 1'b1;
                end
                default: begin
                    if (w_accept) begin
                        r_first <= bus.in_first;
                        if (w_conflict) begin
                            r_state      <= SPLIT_OLD;
                            r_d1         <= bus.in_first ? SLOT_IDLE : w_s1;
                            r_d2         <= bus.in_first ? w_s2 : SLOT_IDLE;
                            r_pend       <= w_yng;
                            r_pend_slot2 <= !bus.in_first;
                            r_out_valid  <= 1'b1;
                            if (r_split_count != {CNT_W{1'b1}}) begin
                                r_split_count <= r_split_count +
                                                 {{(CNT_W-1){1'b0}}, 1'b1};
                            end else begin
                                r_split_count <= r_split_count;
                            end
                        end else begin
                            r_state     <= PAIR;
                            r_d1        <= f_live(bus.in_op_valid_1, w_s1);
                            r_d2        <= f_live(bus.in_op_valid_2, w_s2);
                            r_out_valid <= bus.in_op_valid_1 || bus.in_op_valid_2;
                        end
                    end else begin
                        r_state     <= IDLE;
                        r_d1        <= SLOT_IDLE;
                        r_d2        <= SLOT_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.dm_addr_1   = r_d1.addr;
    assign bus.dm_size_1   = r_d1.size;
    assign bus.dm_signed_1 = r_d1.sgn;
    assign bus.dm_we_1     = r_d1.we;
    assign bus.dm_wdata_1  = r_d1.wdata;
    assign bus.dm_addr_2   = r_d2.addr;
    assign bus.dm_size_2   = r_d2.size;
    assign bus.dm_signed_2 = r_d2.sgn;
    assign bus.dm_we_2     = r_d2.we;
    assign bus.dm_wdata_2  = r_d2.wdata;
    assign bus.dm_first    = r_first;
    assign bus.out_valid   = r_out_valid;
    assign split_count     = r_split_count;

endmodule
